apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Request/response to APB bridge: IDLE -> SETUP -> ACCESS, all APB and response outputs registered.
// Optional ACCESS-phase timeout abort is built only when APB_TIMEOUT_EN is defined.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    accept_s;
  logic                    done_s;
  logic                    timeout_s;
  logic                    timeout_hit_s;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    psel_r;
  logic                    penable_r;
  logic                    pwrite_r;
  logic [ADDR_WIDTH-1:0]   paddr_r;
  logic [DATA_WIDTH-1:0]   pwdata_r;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  assign req_ready = (state_r == ST_IDLE);
  assign accept_s  = req_valid && (state_r == ST_IDLE);

  // Next-state decode; PREADY is only looked at while in ACCESS.
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // APB and response outputs; address/data are frozen at acceptance so req_* may change freely.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDR_WIDTH{1'b0}};
      pwdata_r    <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      psel_r      <= (state_nxt_s != ST_IDLE);
      penable_r   <= (state_nxt_s == ST_ACCESS);
      rsp_valid_r <= done_s || timeout_s;
      if (accept_s) begin
        pwrite_r <= req_write;
        paddr_r  <= req_addr;
        pwdata_r <= req_wdata;
      end
      if (done_s) begin
        rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : PRDATA;
      end else if (timeout_s) begin
        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_r;
  logic             rsp_err_r;

  assign timeout_hit_s = (to_cnt_r == CNT_LAST);
  assign rsp_err       = rsp_err_r;

  // Counts ACCESS cycles without PREADY; restarts with every accepted request.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !PREADY) begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end
  end

  // Error flag accompanies each response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_err_r <= 1'b0;
    end else if (done_s || timeout_s) begin
      rsp_err_r <= timeout_s;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  assign PSELx     = psel_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PADDR     = paddr_r;
  assign PWDATA    = pwdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
